// File: rtl/nes_clk_gen_pkg.sv
// Shared types and default timing constants for the NES master-clock divider.
package nes_clk_pkg;

  localparam int unsigned CNT_W = 4;

  localparam int unsigned DEF_NTSC_CPU_DIV = 12;
  localparam int unsigned DEF_PAL_CPU_DIV  = 16;
  localparam int unsigned DEF_NTSC_PPU_DIV = 4;
  localparam int unsigned DEF_PAL_PPU_DIV  = 5;
  localparam int unsigned DEF_NTSC_M2_RISE = 4;
  localparam int unsigned DEF_PAL_M2_RISE  = 6;

  typedef enum logic {
    REGION_NTSC = 1'b0,
    REGION_PAL  = 1'b1
  } region_t;

  // Dividers are carried as terminal count (N-1) so a divide-by-16 fits CNT_W.
  typedef struct packed {
    logic [CNT_W-1:0] cpu_max;
    logic [CNT_W-1:0] ppu_max;
    logic [CNT_W-1:0] phi2_rise;
    logic [CNT_W-1:0] m2_rise;
  } timing_t;

  typedef struct packed {
    logic pause_ack;
    logic cpu_ce;
    logic apu_ce;
    logic ppu_ce;
    logic phi2;
    logic m2;
  } outs_t;

  function automatic timing_t make_timing(int unsigned cpu_div, int unsigned ppu_div,
                                          int unsigned m2_at);
    timing_t t;
    t.cpu_max   = CNT_W'(cpu_div - 1);
    t.ppu_max   = CNT_W'(ppu_div - 1);
    t.phi2_rise = CNT_W'(cpu_div / 2);
    t.m2_rise   = CNT_W'(m2_at);
    return t;
  endfunction

endpackage

// File: rtl/nes_clk_gen_if.sv
// Region/pause controls in, CPU/PPU/APU timing strobes and bus phases out.
interface nes_clk_gen_if;
  logic pal;
  logic pause_req;
  logic pause_ack;
  logic cpu_ce;
  logic apu_ce;
  logic ppu_ce;
  logic phi2;
  logic m2;

  modport master (
    input  pal, pause_req,
    output pause_ack, cpu_ce, apu_ce, ppu_ce, phi2, m2
  );

  modport slave (
    output pal, pause_req,
    input  pause_ack, cpu_ce, apu_ce, ppu_ce, phi2, m2
  );
endinterface

// File: rtl/nes_clk_gen_clk_divider.sv
// Modulo-(max_i+1) counter with freeze; exposes the next count and terminal count.
module clk_divider
  import nes_clk_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] max_i,
  input  logic             freeze_i,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // wrap_o flags the terminal count regardless of freeze, so the caller can
  // decide to freeze on it without a combinational loop.
  assign wrap_o  = (cnt_q == max_i);
  assign cnt_d_o = cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= max_i;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nes_clk_gen.sv
// NES master-clock divider: CPU/APU/PPU enables, phi2/M2 phases and pause handshake.
module nes_clk_gen
  import nes_clk_pkg::*;
#(
  parameter int unsigned NTSC_CPU_DIV = DEF_NTSC_CPU_DIV,
  parameter int unsigned PAL_CPU_DIV  = DEF_PAL_CPU_DIV,
  parameter int unsigned NTSC_PPU_DIV = DEF_NTSC_PPU_DIV,
  parameter int unsigned PAL_PPU_DIV  = DEF_PAL_PPU_DIV,
  parameter int unsigned NTSC_M2_RISE = DEF_NTSC_M2_RISE,
  parameter int unsigned PAL_M2_RISE  = DEF_PAL_M2_RISE
) (
  input  logic          clk,
  input  logic          reset_n,
  nes_clk_gen_if.master bus
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_PAUSED = 1'b1;

  localparam timing_t NTSC_TIM = make_timing(NTSC_CPU_DIV, NTSC_PPU_DIV, NTSC_M2_RISE);
  localparam timing_t PAL_TIM  = make_timing(PAL_CPU_DIV, PAL_PPU_DIV, PAL_M2_RISE);

  region_t          pal_q;
  region_t          region_sel;
  timing_t          tim;
  logic [0:0]       state_q, state_d;
  logic             apu_phase_q, apu_phase_d;
  outs_t            out_q, out_d;
  logic             freeze;
  logic [CNT_W-1:0] ccnt_d, pcnt_d;
  logic             cpu_wrap, ppu_wrap;
  logic             cpu_adv, ppu_adv;

  // While in reset the live pal input selects the divisors, so the counters
  // reload with the terminal count of the region being latched on that edge.
  assign region_sel = reset_n ? pal_q : region_t'(bus.pal);
  assign tim        = (region_sel == REGION_PAL) ? PAL_TIM : NTSC_TIM;

  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.pause_req && cpu_wrap) begin
          state_d = ST_PAUSED;
          freeze  = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (bus.pause_req) freeze = 1'b1;
        else               state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  clk_divider u_cpu_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .max_i    (tim.cpu_max),
    .freeze_i (freeze),
    .cnt_d_o  (ccnt_d),
    .wrap_o   (cpu_wrap)
  );

  clk_divider u_ppu_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .max_i    (tim.ppu_max),
    .freeze_i (freeze),
    .cnt_d_o  (pcnt_d),
    .wrap_o   (ppu_wrap)
  );

  // Outputs decode next-state counts so each flop matches the count it sits beside.
  always_comb begin
    cpu_adv     = cpu_wrap && (ccnt_d == '0);
    ppu_adv     = ppu_wrap && (pcnt_d == '0);
    apu_phase_d = apu_phase_q ^ cpu_adv;
    out_d       = '0;
    if (state_d == ST_PAUSED) begin
      out_d.pause_ack = 1'b1;
    end else begin
      out_d.cpu_ce = cpu_adv;
      out_d.apu_ce = cpu_adv && !apu_phase_d;
      out_d.ppu_ce = ppu_adv;
      out_d.phi2   = (ccnt_d >= tim.phi2_rise);
      out_d.m2     = (ccnt_d >= tim.m2_rise);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pal_q       <= region_t'(bus.pal);
      state_q     <= ST_RUN;
      apu_phase_q <= 1'b1;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      apu_phase_q <= apu_phase_d;
      out_q       <= out_d;
    end
  end

  assign bus.pause_ack = out_q.pause_ack;
  assign bus.cpu_ce    = out_q.cpu_ce;
  assign bus.apu_ce    = out_q.apu_ce;
  assign bus.ppu_ce    = out_q.ppu_ce;
  assign bus.phi2      = out_q.phi2;
  assign bus.m2        = out_q.m2;

endmodule

// File: tb/tb_nes_clk_gen.sv
// Scoreboard bench for nes_clk_gen: expectations queued per edge, checked by a monitor.
module tb_nes_clk_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  nes_clk_gen_if bif ();

  nes_clk_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [5:0] exp_q[$];
  string      name_q[$];
  int         tick_q[$];

  string cur_test = "init";

  // Reference: t counts unfrozen edges since reset (t=0 is the first running edge).
  bit m_pal;
  int t;
  bit m_paused;

  function automatic logic [5:0] run_vec(int tt, bit pl);
    int cd, pd, mr, c;
    cd = pl ? 16 : 12;
    pd = pl ? 5 : 4;
    mr = pl ? 6 : 4;
    c  = tt % cd;
    // {pause_ack, cpu_ce, apu_ce, ppu_ce, phi2, m2}
    return {1'b0, c == 0, (tt % (2 * cd)) == 0, (tt % pd) == 0, c >= cd / 2, c >= mr};
  endfunction

  task automatic step(input bit r, input bit p, input bit q);
    logic [5:0] e;
    int cd;
    @(negedge clk);
    reset_n       = r;
    bif.pal       = p;
    bif.pause_req = q;
    if (!r) begin
      m_pal    = p;
      t        = -1;
      m_paused = 1'b0;
      e        = 6'b000000;
    end else begin
      cd = m_pal ? 16 : 12;
      if (m_paused) begin
        if (q) begin
          e = 6'b100000;
        end else begin
          m_paused = 1'b0;
          t++;
          e = run_vec(t, m_pal);
        end
      end else if (q && (((t % cd) + cd) % cd) == cd - 1) begin
        m_paused = 1'b1;
        e        = 6'b100000;
      end else begin
        t++;
        e = run_vec(t, m_pal);
      end
    end
    exp_q.push_back(e);
    name_q.push_back(cur_test);
    tick_q.push_back(t);
  endtask

  task automatic reset_seq(input bit p, input bit q, input int n);
    repeat (n) step(1'b0, p, q);
  endtask

  initial begin : monitor
    logic [5:0] act, e;
    string n;
    int c;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        c   = tick_q.pop_front();
        act = {bif.pause_ack, bif.cpu_ce, bif.apu_ce, bif.ppu_ce, bif.phi2, bif.m2};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s t=%0d {ack,cpu,apu,ppu,phi2,m2} got=%b want=%b", n, c, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    bif.pal       = 1'b0;
    bif.pause_req = 1'b0;

    cur_test = "ntsc_run";
    reset_seq(1'b0, 1'b0, 3);
    repeat (48) step(1'b1, 1'b0, 1'b0);

    cur_test = "pal_run";
    reset_seq(1'b1, 1'b0, 3);
    repeat (80) step(1'b1, 1'b1, 1'b0);

    cur_test = "pal_toggle_ignored";
    reset_seq(1'b0, 1'b0, 2);
    for (int i = 0; i < 60; i++) step(1'b1, i >= 30, 1'b0);

    cur_test = "pause_ntsc";
    reset_seq(1'b0, 1'b0, 2);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !m_paused; i++) step(1'b1, 1'b0, 1'b1);
    repeat (20) step(1'b1, 1'b0, 1'b1);
    repeat (30) step(1'b1, 1'b0, 1'b0);

    cur_test = "pause_pulse_no_effect";
    reset_seq(1'b0, 1'b0, 2);
    for (int i = 0; i < 42; i++) step(1'b1, 1'b0, (i >= 2) && (i <= 5));

    cur_test = "reset_while_paused";
    reset_seq(1'b0, 1'b0, 2);
    repeat (12) step(1'b1, 1'b0, 1'b0);
    repeat (14) step(1'b1, 1'b0, 1'b1);
    reset_seq(1'b0, 1'b1, 2);
    repeat (24) step(1'b1, 1'b0, 1'b0);

    cur_test = "pal_pause_at_release";
    reset_seq(1'b1, 1'b0, 2);
    repeat (5) step(1'b1, 1'b1, 1'b1);
    repeat (40) step(1'b1, 1'b1, 1'b0);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
